oven_game: RTL and testbench
============================

// Module: oven_game
// PURPOSE
// - Bakery minigame: one "oven" light per round on one of 7 positions; player presses the matching button before timeout.
// - Slot-compatible with the existing minigames: started by the top-level jogar pulse after the intervalo state.
// - Returns estado/jogadas/pontuacao through the top-level output mux and holds pronto when finished.
// PARAMETERS
// - ROUNDS        default 7         rounds per game, legal range 1..7
// - TIMEOUT_EASY  default 3000      clocks allowed per round when dificuldade=0
// - TIMEOUT_HARD  default 1500      clocks allowed per round when dificuldade=1
// - SEED          default 7'h01     LFSR value after reset; must be nonzero
// PORTS
// - clock        in   1  system clock (divided clock from top)
// - reset        in   1  synchronous, active-high reset
// - jogar        in   1  1-cycle start pulse; accepted only in IDLE or FIM
// - dificuldade  in   1  difficulty; sampled in PREP, then held for the whole game
// - botoes       in   7  buttons, active-high (already inverted by top)
// - estado       out  4  current state code (table below)
// - jogadas      out  7  one-hot target in SHOW; 0 in all other states
// - pontuacao    out  3  hits so far; saturates at 7
// - pronto       out  1  high while in FIM
// BEHAVIOUR
// - Reset: state=IDLE; estado=0; jogadas=0; pontuacao=0; pronto=0; round=0; timer=0; lfsr=SEED; botoes_prev=0.
// - Edge detect: botoes_prev <= botoes every cycle; press = botoes & ~botoes_prev.
// - LFSR: 7-bit, shift left, new lsb = q[6]^q[5]. Advances once on PREP->SHOW and once on NEXT->SHOW.
// - Target index idx = (lfsr[2:0]==7) ? 0 : lfsr[2:0], computed from the advanced value; target = 1<<idx.
// - States and estado codes:
//   - IDLE 4'h0: wait; jogar -> PREP.
//   - PREP 4'h2: 1 cycle; pontuacao=0, round=0, timer=0; latch dificuldade; advance lfsr -> SHOW.
//   - SHOW 4'h3: jogadas=target; timer++ each cycle.
//     - press!=0: latch press into pv -> CHECK.
//     - otherwise timer==limit-1 -> MISS.
//     - press and timeout in the same cycle: press wins.
//   - CHECK 4'h4: pv==target exactly -> HIT; else MISS. Multiple bits pressed = miss.
//   - HIT 4'h5: 1 cycle; pontuacao <= min(pontuacao+1, 7) -> NEXT.
//   - MISS 4'h6: 1 cycle; if the hard latch is set and the miss came from a wrong press (not a timeout) -> FIM; else -> NEXT.
//   - NEXT 4'h7: round++.
//     - round+1==ROUNDS -> FIM.
//     - else wait until botoes==0; on that cycle advance lfsr, clear timer -> SHOW.
//   - FIM 4'hF: pronto=1; pontuacao held; jogar -> PREP (restart, score cleared in PREP).
// - Unused state encodings -> IDLE next cycle.
// - jogar in PREP..NEXT: ignored.
// - reset mid-game: returns to the reset values on the next edge, including lfsr=SEED.
// - limit = dificuldade latch ? TIMEOUT_HARD : TIMEOUT_EASY; timer is 32 bits wide.
// - Latency: jogar at edge k -> PREP at k+1 -> SHOW at k+2 (jogadas valid).
// - Press latency: rising press seen at edge m -> CHECK at m+1 -> HIT/MISS at m+2 -> NEXT at m+3.
// - A button held from the previous round causes no press: edge detect only.
// TESTING (ROUNDS=3, TIMEOUT_EASY=20, TIMEOUT_HARD=10, SEED=7'h01)
// - Reset, then jogar, dificuldade=0 -> jogadas=0000100, 0010000, 0000001 in rounds 1..3.
//   - Correct press each round -> pontuacao=3, estado=F, pronto=1.
// - Easy mode, no press -> each round times out after 20 SHOW cycles, goes MISS then NEXT.
//   - After 3 rounds: pontuacao=0, pronto=1.
// - Hard mode, round 1, press 0000001 (target 0000100) -> CHECK, MISS, FIM; pontuacao=0.
// - Easy mode, round 1, press 0000101 together -> MISS, round 2 continues, pontuacao stays 0.
// - Hold button 2 across NEXT: game stays in NEXT until release.
//   - Holding the button into round 2 is no press; timeout after 20 cycles.
// - Assert reset during SHOW of round 2 -> IDLE, pontuacao=0, lfsr=01.
//   - A new jogar shows 0000100 again.
// - jogar pulses in SHOW are ignored; jogar in FIM restarts with pontuacao cleared.

Source files
------------

// File: rtl/oven_game.sv
// oven_game: bakery reflex minigame, one oven lights per round and the player
// must press the matching button before the round times out.
module oven_game #(
   parameter int         ROUNDS       = 7,
   parameter int         TIMEOUT_EASY = 3000,
   parameter int         TIMEOUT_HARD = 1500,
   parameter logic [6:0] SEED         = 7'h01
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       jogar,
   input  logic       dificuldade,
   input  logic [6:0] botoes,
   output logic [3:0] estado,
   output logic [6:0] jogadas,
   output logic [2:0] pontuacao,
   output logic       pronto
);
   typedef enum logic [3:0] {
      IDLE  = 4'h0,
      PREP  = 4'h2,
      SHOW  = 4'h3,
      CHECK = 4'h4,
      HIT   = 4'h5,
      MISS  = 4'h6,
      NEXT  = 4'h7,
      FIM   = 4'hF
   } state_t;
   state_t      state, state_n;
   logic [6:0]  lfsr, lfsr_adv, botoes_prev, press, pv, target;
   logic [2:0]  round, idx;
   logic [31:0] timer, limit;
   logic        hard, timeout, last, advance;
   assign press    = botoes & ~botoes_prev;
   assign lfsr_adv = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
   assign idx      = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
   assign target   = 7'd1 << idx;
   assign limit    = hard ? 32'(TIMEOUT_HARD) : 32'(TIMEOUT_EASY);
   assign timeout  = timer == limit - 32'd1;
   assign last     = int'(round) + 1 == ROUNDS;
   // the next round only starts once every button has been released
   assign advance  = (state == PREP) || (state == NEXT && !last && botoes == '0);
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end
   always_comb begin
      state_n = IDLE;
      case (state)
         IDLE, FIM: state_n = jogar ? PREP : state;
         PREP:      state_n = SHOW;
         SHOW:      state_n = (press != '0) ? CHECK : timeout ? MISS : SHOW;
         CHECK:     state_n = (pv == target) ? HIT : MISS;
         HIT:       state_n = NEXT;
         MISS:      state_n = (hard && pv != '0) ? FIM : NEXT;
         NEXT:      state_n = last ? FIM : (botoes == '0) ? SHOW : NEXT;
         default:   state_n = IDLE;
      endcase
   end
   always_comb begin
      estado  = state;
      jogadas = (state == SHOW) ? target : '0;
      pronto  = state == FIM;
   end
   // pv is rewritten every SHOW cycle, so a timeout leaves it zero and MISS can tell it apart from a wrong press
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr        <= SEED;
         botoes_prev <= '0;
         pv          <= '0;
         round       <= '0;
         timer       <= '0;
         hard        <= 1'b0;
         pontuacao   <= '0;
      end else begin
         botoes_prev <= botoes;
         if (state_n == PREP) begin
            pontuacao <= '0;
            round     <= '0;
         end
         if (state == PREP) hard <= dificuldade;
         if (advance) lfsr <= lfsr_adv;
         if (state == SHOW) pv <= press;
         timer <= advance ? '0 : (state == SHOW) ? timer + 32'd1 : timer;
         if (state == HIT && pontuacao != 3'd7) pontuacao <= pontuacao + 3'd1;
         if (state == NEXT && (last || botoes == '0)) round <= round + 3'd1;
      end
   end
endmodule

// File: tb/tb_oven_game.sv
// tb_oven_game: vector table plus hand sequences; expectations are queued when
// inputs are driven and compared just after the following clock edge.
module tb_oven_game;
   logic       clock = 1'b0;
   logic       reset, jogar, dificuldade;
   logic [6:0] botoes, jogadas;
   logic [3:0] estado;
   logic [2:0] pontuacao;
   logic       pronto;
   int         checks = 0;
   int         failures = 0;
   typedef struct {
      logic [3:0] es;
      logic [6:0] jd;
      logic [2:0] pt;
      logic       pr;
      string      tag;
   } exp_t;
   typedef struct {
      logic       rs, jg, dif;
      logic [6:0] bt;
      logic [3:0] es;
      logic [6:0] jd;
      logic [2:0] pt;
      logic       pr;
      string      tag;
   } vec_t;
   exp_t       q[$];
   exp_t       e;
   vec_t       tbl[16];
   logic [6:0] m;
   oven_game #(.ROUNDS(3), .TIMEOUT_EASY(20), .TIMEOUT_HARD(10), .SEED(7'h01)) dut (
      .clock(clock), .reset(reset), .jogar(jogar), .dificuldade(dificuldade),
      .botoes(botoes), .estado(estado), .jogadas(jogadas), .pontuacao(pontuacao), .pronto(pronto)
   );
   always #5 clock = ~clock;
   function automatic logic [6:0] adv(input logic [6:0] v);
      return {v[5:0], v[6] ^ v[5]};
   endfunction
   function automatic logic [6:0] tgt(input logic [6:0] v);
      logic [2:0] i;
      i = (v[2:0] == 3'd7) ? 3'd0 : v[2:0];
      return 7'd1 << i;
   endfunction
   task automatic cyc(input logic rs, input logic jg, input logic dif, input logic [6:0] bt,
                      input logic [3:0] es, input logic [6:0] jd, input logic [2:0] pt,
                      input logic pr, input string tag);
      @(negedge clock);
      reset = rs;
      jogar = jg;
      dificuldade = dif;
      botoes = bt;
      q.push_back('{es, jd, pt, pr, tag});
   endtask
   always @(posedge clock) begin
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         checks++;
         if ({estado, jogadas, pontuacao, pronto} !== {e.es, e.jd, e.pt, e.pr}) begin
            failures++;
            $display("FAIL %s: got estado=%h jogadas=%b pontuacao=%0d pronto=%b, want estado=%h jogadas=%b pontuacao=%0d pronto=%b",
                     e.tag, estado, jogadas, pontuacao, pronto, e.es, e.jd, e.pt, e.pr);
         end
      end
   end
   initial begin
      reset = 1'b1; jogar = 1'b0; dificuldade = 1'b0; botoes = '0;
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 7'h00, 4'h0, 7'h00, 3'd0, 1'b0, "reset"};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 7'h00, 4'h2, 7'h00, 3'd0, 1'b0, "prep"};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 7'h00, 4'h3, 7'h04, 3'd0, 1'b0, "show_r1"};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 7'h04, 4'h4, 7'h00, 3'd0, 1'b0, "check_r1"};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 7'h04, 4'h5, 7'h00, 3'd0, 1'b0, "hit_r1"};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 7'h00, 4'h7, 7'h00, 3'd1, 1'b0, "next_r1"};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 7'h00, 4'h3, 7'h10, 3'd1, 1'b0, "show_r2"};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 7'h10, 4'h4, 7'h00, 3'd1, 1'b0, "check_r2"};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 7'h00, 4'h5, 7'h00, 3'd1, 1'b0, "hit_r2"};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 7'h00, 4'h7, 7'h00, 3'd2, 1'b0, "next_r2"};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 7'h00, 4'h3, 7'h01, 3'd2, 1'b0, "show_r3"};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 7'h01, 4'h4, 7'h00, 3'd2, 1'b0, "check_r3"};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 7'h00, 4'h5, 7'h00, 3'd2, 1'b0, "hit_r3"};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 7'h00, 4'h7, 7'h00, 3'd3, 1'b0, "next_r3"};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 7'h00, 4'hF, 7'h00, 3'd3, 1'b1, "fim"};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 7'h00, 4'hF, 7'h00, 3'd3, 1'b1, "fim_hold"};
      for (int i = 0; i < 16; i++)
         cyc(tbl[i].rs, tbl[i].jg, tbl[i].dif, tbl[i].bt, tbl[i].es, tbl[i].jd, tbl[i].pt, tbl[i].pr, tbl[i].tag);
      // restart from FIM in easy mode, no presses; stray jogar and dificuldade during SHOW
      m = 7'h08;
      cyc(1'b0, 1'b1, 1'b0, 7'h00, 4'h2, 7'h00, 3'd0, 1'b0, "restart_prep");
      for (int r = 0; r < 3; r++) begin
         m = adv(m);
         for (int t = 0; t < 20; t++)
            cyc(1'b0, t == 5, t >= 7, 7'h00, 4'h3, tgt(m), 3'd0, 1'b0, "easy_show");
         cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h6, 7'h00, 3'd0, 1'b0, "easy_miss");
         cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h7, 7'h00, 3'd0, 1'b0, "easy_next");
      end
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'hF, 7'h00, 3'd0, 1'b1, "easy_fim");
      // hard mode: timeout continues, a wrong press ends the game
      cyc(1'b0, 1'b1, 1'b1, 7'h00, 4'h2, 7'h00, 3'd0, 1'b0, "hard_prep");
      m = adv(m);
      for (int t = 0; t < 10; t++)
         cyc(1'b0, 1'b0, 1'b1, 7'h00, 4'h3, tgt(m), 3'd0, 1'b0, "hard_show");
      cyc(1'b0, 1'b0, 1'b1, 7'h00, 4'h6, 7'h00, 3'd0, 1'b0, "hard_tmo_miss");
      cyc(1'b0, 1'b0, 1'b1, 7'h00, 4'h7, 7'h00, 3'd0, 1'b0, "hard_tmo_next");
      m = adv(m);
      cyc(1'b0, 1'b0, 1'b1, 7'h00, 4'h3, tgt(m), 3'd0, 1'b0, "hard_show_r2");
      cyc(1'b0, 1'b0, 1'b1, (tgt(m) == 7'h01) ? 7'h02 : 7'h01, 4'h4, 7'h00, 3'd0, 1'b0, "hard_wrong");
      cyc(1'b0, 1'b0, 1'b1, 7'h00, 4'h6, 7'h00, 3'd0, 1'b0, "hard_wrong_miss");
      cyc(1'b0, 1'b0, 1'b1, 7'h00, 4'hF, 7'h00, 3'd0, 1'b1, "hard_wrong_fim");
      // hard mode after reset: press 0000001 against target 0000100
      cyc(1'b1, 1'b0, 1'b0, 7'h00, 4'h0, 7'h00, 3'd0, 1'b0, "reset2");
      cyc(1'b0, 1'b1, 1'b1, 7'h00, 4'h2, 7'h00, 3'd0, 1'b0, "hard2_prep");
      cyc(1'b0, 1'b0, 1'b1, 7'h00, 4'h3, 7'h04, 3'd0, 1'b0, "hard2_show");
      cyc(1'b0, 1'b0, 1'b1, 7'h01, 4'h4, 7'h00, 3'd0, 1'b0, "hard2_check");
      cyc(1'b0, 1'b0, 1'b1, 7'h00, 4'h6, 7'h00, 3'd0, 1'b0, "hard2_miss");
      cyc(1'b0, 1'b0, 1'b1, 7'h00, 4'hF, 7'h00, 3'd0, 1'b1, "hard2_fim");
      // easy: double press misses, held button stalls NEXT, held release gives no press
      cyc(1'b1, 1'b0, 1'b0, 7'h00, 4'h0, 7'h00, 3'd0, 1'b0, "reset3");
      cyc(1'b0, 1'b1, 1'b0, 7'h00, 4'h2, 7'h00, 3'd0, 1'b0, "multi_prep");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h3, 7'h04, 3'd0, 1'b0, "multi_show");
      cyc(1'b0, 1'b0, 1'b0, 7'h05, 4'h4, 7'h00, 3'd0, 1'b0, "multi_check");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h6, 7'h00, 3'd0, 1'b0, "multi_miss");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h7, 7'h00, 3'd0, 1'b0, "multi_next");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h3, 7'h10, 3'd0, 1'b0, "multi_show_r2");
      cyc(1'b0, 1'b0, 1'b0, 7'h10, 4'h4, 7'h00, 3'd0, 1'b0, "hold_check");
      cyc(1'b0, 1'b0, 1'b0, 7'h10, 4'h5, 7'h00, 3'd0, 1'b0, "hold_hit");
      for (int t = 0; t < 4; t++)
         cyc(1'b0, 1'b0, 1'b0, 7'h10, 4'h7, 7'h00, 3'd1, 1'b0, "hold_next");
      for (int t = 0; t < 20; t++)
         cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h3, 7'h01, 3'd1, 1'b0, "release_show");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h6, 7'h00, 3'd1, 1'b0, "release_miss");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h7, 7'h00, 3'd1, 1'b0, "release_next");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'hF, 7'h00, 3'd1, 1'b1, "release_fim");
      // reset during round 2 restores the seed
      cyc(1'b1, 1'b0, 1'b0, 7'h00, 4'h0, 7'h00, 3'd0, 1'b0, "reset4");
      cyc(1'b0, 1'b1, 1'b0, 7'h00, 4'h2, 7'h00, 3'd0, 1'b0, "mid_prep");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h3, 7'h04, 3'd0, 1'b0, "mid_show");
      cyc(1'b0, 1'b0, 1'b0, 7'h04, 4'h4, 7'h00, 3'd0, 1'b0, "mid_check");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h5, 7'h00, 3'd0, 1'b0, "mid_hit");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h7, 7'h00, 3'd1, 1'b0, "mid_next");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h3, 7'h10, 3'd1, 1'b0, "mid_show_r2");
      cyc(1'b1, 1'b0, 1'b0, 7'h00, 4'h0, 7'h00, 3'd0, 1'b0, "mid_reset");
      cyc(1'b0, 1'b1, 1'b0, 7'h00, 4'h2, 7'h00, 3'd0, 1'b0, "after_prep");
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 4'h3, 7'h04, 3'd0, 1'b0, "after_show");
      @(negedge clock);
      @(negedge clock);
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
